// File: rtl/int_controller.sv
// Prioritised, vectored interrupt controller: synchronises and edge-detects int_e lines,
// keeps pending/mask/in-service state and raises one registered request with a vector.
module int_controller #(
    parameter int               N_SRC       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               VEC_W       = 16,
    parameter logic [VEC_W-1:0] VEC_BASE    = 16'h0010,
    parameter int               VEC_SHIFT   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] int_e,
    output logic             irq_req,
    output logic [VEC_W-1:0] irq_vec,
    input  logic             irq_ack,
    input  logic             irq_ret,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [7:0]       cfg_wdata,
    output logic [7:0]       cfg_rdata
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    localparam logic [1:0] ADDR_IMR  = 2'd0;
    localparam logic [1:0] ADDR_IPR  = 2'd1;
    localparam logic [1:0] ADDR_ISR  = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } state_e;

    logic [N_SRC-1:0] sync_q [SYNC_STAGES];
    logic [N_SRC-1:0] sync_last_q;

    logic [N_SRC-1:0] ipr_q, ipr_d;
    logic [N_SRC-1:0] isr_q, isr_d;
    logic [N_SRC-1:0] imr_q, imr_d;
    logic             gie_q, gie_d;
    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [VEC_W-1:0] vec_q, vec_d;

    logic [N_SRC-1:0] sync_out;
    logic [N_SRC-1:0] edge_det;
    logic [N_SRC-1:0] w1c_mask;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] idx_mask;
    logic [N_SRC-1:0] ack_clr;
    logic [N_SRC-1:0] ack_set;
    logic [N_SRC-1:0] ret_clr;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] svc_idx;
    logic             win_valid;
    logic             wr_imr, wr_ipr, wr_ctrl;

    // Index 0 is highest priority, so the lowest set bit wins.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_SRC-1:0] v);
        lowest_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_idx = IDX_W'(i);
            end
        end
    endfunction

    // Input synchroniser and rising-edge detector.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the synchroniser stages are reset too, so no stale level can fake an edge after reset.
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            sync_last_q <= '0;
        end else begin
            sync_q[0] <= int_e;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            sync_last_q <= sync_out;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign edge_det = sync_out & ~sync_last_q;

    assign wr_imr   = cfg_we && (cfg_addr == ADDR_IMR);
    assign wr_ipr   = cfg_we && (cfg_addr == ADDR_IPR);
    assign wr_ctrl  = cfg_we && (cfg_addr == ADDR_CTRL);
    assign w1c_mask = wr_ipr ? cfg_wdata[N_SRC-1:0] : '0;

    // Arbitration sees only registered values, so a same-cycle cfg write takes effect next cycle.
    assign eligible  = ipr_q & imr_q & {N_SRC{gie_q}};
    assign win_idx   = lowest_idx(eligible);
    assign svc_idx   = lowest_idx(isr_q);
    assign win_valid = (|eligible) && ((isr_q == '0) || (win_idx < svc_idx));

    assign idx_mask  = N_SRC'(1) << idx_q;
    assign ret_clr   = irq_ret ? (isr_q & (~isr_q + N_SRC'(1))) : '0;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        ack_clr = '0;
        ack_set = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    idx_d   = win_idx;
                    vec_d   = VEC_BASE + (VEC_W'(win_idx) << VEC_SHIFT);
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Acknowledge beats withdrawal; the vector stays frozen until one of them happens.
                if (irq_ack) begin
                    ack_clr = idx_mask;
                    ack_set = idx_mask;
                    state_d = ST_IDLE;
                end else if (((ipr_q & idx_mask) == '0) || ((imr_q & idx_mask) == '0) || !gie_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A fresh edge re-sets a pending bit even when ack or W1C clears it in the same cycle.
    assign ipr_d = (ipr_q & ~w1c_mask & ~ack_clr) | edge_det;
    // Return retires the old highest-priority in-service bit before the new entry is recorded.
    assign isr_d = (isr_q & ~ret_clr) | ack_set;
    assign imr_d = wr_imr ? cfg_wdata[N_SRC-1:0] : imr_q;
    assign gie_d = wr_ctrl ? cfg_wdata[0] : gie_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ipr_q   <= '0;
            isr_q   <= '0;
            imr_q   <= '0;
            gie_q   <= 1'b0;
            state_q <= ST_IDLE;
            idx_q   <= '0;
            vec_q   <= '0;
        end else begin
            ipr_q   <= ipr_d;
            isr_q   <= isr_d;
            imr_q   <= imr_d;
            gie_q   <= gie_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
        end
    end

    assign irq_req = (state_q == ST_REQ);
    assign irq_vec = vec_q;

    always_comb begin
        cfg_rdata = '0;
        unique case (cfg_addr)
            ADDR_IMR:  cfg_rdata[N_SRC-1:0] = imr_q;
            ADDR_IPR:  cfg_rdata[N_SRC-1:0] = ipr_q;
            ADDR_ISR:  cfg_rdata[N_SRC-1:0] = isr_q;
            ADDR_CTRL: cfg_rdata[0]         = gie_q;
            default:   cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_int_controller.sv
// Self-checking bench for int_controller: a directed vector table for the main flows,
// then hand-written sequences for withdrawal, simultaneous events, masking and reset.
module tb_int_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  int_e;
    logic        irq_req;
    logic [15:0] irq_vec;
    logic        irq_ack;
    logic        irq_ret;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_wdata;
    logic [7:0]  cfg_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    int_controller dut (
        .clk       (clk),
        .reset     (reset),
        .int_e     (int_e),
        .irq_req   (irq_req),
        .irq_vec   (irq_vec),
        .irq_ack   (irq_ack),
        .irq_ret   (irq_ret),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ex;
        logic        ack;
        logic        ret;
        logic        we;
        logic [1:0]  addr;
        logic [7:0]  wd;
        logic        exp_req;
        logic [15:0] exp_vec;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [7:0] ex, logic ack, logic ret, logic we, logic [1:0] addr,
                                logic [7:0] wd, logic exp_req, logic [15:0] exp_vec, logic [7:0] exp_rd);
        vec_t v;
        v.ex = ex; v.ack = ack; v.ret = ret; v.we = we; v.addr = addr; v.wd = wd;
        v.exp_req = exp_req; v.exp_vec = exp_vec; v.exp_rd = exp_rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [7:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_we    = 1'b0;
        cfg_wdata = 8'h00;
    endtask

    task automatic rd_check(input string name, input logic [1:0] addr, input logic [7:0] exp);
        cfg_addr = addr;
        #1;
        check(name, 32'(cfg_rdata), 32'(exp));
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic pulse_ret();
        irq_ret = 1'b1;
        tick();
        irq_ret = 1'b0;
    endtask

    task automatic check_req(input string name, input logic exp_req, input logic [15:0] exp_vec);
        check({name, ".req"}, 32'(irq_req), 32'(exp_req));
        if (exp_req) begin
            check({name, ".vec"}, 32'(irq_vec), 32'(exp_vec));
        end
    endtask

    initial begin
        // Priority, vectoring, return and nesting flows, one row per clock.
        //                ex    ack  ret  we   addr  wd     req  vec       rd
        tbl.push_back(mk(8'h00, 0, 0, 1, 2'd0, 8'hFF, 0, 16'h0000, 8'hFF));
        tbl.push_back(mk(8'h00, 0, 0, 1, 2'd3, 8'hFF, 0, 16'h0000, 8'h01));
        tbl.push_back(mk(8'h08, 0, 0, 0, 2'd1, 8'h00, 0, 16'h0000, 8'h00));
        tbl.push_back(mk(8'h08, 0, 0, 0, 2'd1, 8'h00, 0, 16'h0000, 8'h00));
        tbl.push_back(mk(8'h08, 0, 0, 0, 2'd1, 8'h00, 0, 16'h0000, 8'h08));
        tbl.push_back(mk(8'h08, 0, 0, 0, 2'd1, 8'h00, 1, 16'h001C, 8'h08));
        tbl.push_back(mk(8'h00, 1, 0, 0, 2'd2, 8'h00, 0, 16'h0000, 8'h08));
        tbl.push_back(mk(8'h00, 0, 0, 0, 2'd1, 8'h00, 0, 16'h0000, 8'h00));
        tbl.push_back(mk(8'h00, 0, 1, 0, 2'd2, 8'h00, 0, 16'h0000, 8'h00));
        tbl.push_back(mk(8'h22, 0, 0, 0, 2'd1, 8'h00, 0, 16'h0000, 8'h00));
        tbl.push_back(mk(8'h22, 0, 0, 0, 2'd1, 8'h00, 0, 16'h0000, 8'h00));
        tbl.push_back(mk(8'h22, 0, 0, 0, 2'd1, 8'h00, 0, 16'h0000, 8'h22));
        tbl.push_back(mk(8'h22, 0, 0, 0, 2'd1, 8'h00, 1, 16'h0014, 8'h22));
        tbl.push_back(mk(8'h00, 1, 0, 0, 2'd2, 8'h00, 0, 16'h0000, 8'h02));
        tbl.push_back(mk(8'h00, 0, 1, 0, 2'd2, 8'h00, 0, 16'h0000, 8'h00));
        tbl.push_back(mk(8'h00, 0, 0, 0, 2'd1, 8'h00, 1, 16'h0024, 8'h20));
        tbl.push_back(mk(8'h00, 1, 0, 0, 2'd2, 8'h00, 0, 16'h0000, 8'h20));
        tbl.push_back(mk(8'h00, 0, 1, 0, 2'd2, 8'h00, 0, 16'h0000, 8'h00));
        tbl.push_back(mk(8'h00, 0, 0, 0, 2'd1, 8'h00, 0, 16'h0000, 8'h00));
        tbl.push_back(mk(8'h04, 0, 0, 0, 2'd1, 8'h00, 0, 16'h0000, 8'h00));
        tbl.push_back(mk(8'h04, 0, 0, 0, 2'd1, 8'h00, 0, 16'h0000, 8'h00));
        tbl.push_back(mk(8'h04, 0, 0, 0, 2'd1, 8'h00, 0, 16'h0000, 8'h04));
        tbl.push_back(mk(8'h04, 0, 0, 0, 2'd1, 8'h00, 1, 16'h0018, 8'h04));
        tbl.push_back(mk(8'h00, 1, 0, 0, 2'd2, 8'h00, 0, 16'h0000, 8'h04));
        tbl.push_back(mk(8'h40, 0, 0, 0, 2'd1, 8'h00, 0, 16'h0000, 8'h00));
        tbl.push_back(mk(8'h40, 0, 0, 0, 2'd1, 8'h00, 0, 16'h0000, 8'h00));
        tbl.push_back(mk(8'h40, 0, 0, 0, 2'd1, 8'h00, 0, 16'h0000, 8'h40));
        tbl.push_back(mk(8'h40, 0, 0, 0, 2'd1, 8'h00, 0, 16'h0000, 8'h40));
        tbl.push_back(mk(8'h41, 0, 0, 0, 2'd1, 8'h00, 0, 16'h0000, 8'h40));
        tbl.push_back(mk(8'h41, 0, 0, 0, 2'd1, 8'h00, 0, 16'h0000, 8'h40));
        tbl.push_back(mk(8'h41, 0, 0, 0, 2'd1, 8'h00, 0, 16'h0000, 8'h41));
        tbl.push_back(mk(8'h41, 0, 0, 0, 2'd1, 8'h00, 1, 16'h0010, 8'h41));
        tbl.push_back(mk(8'h00, 1, 0, 0, 2'd2, 8'h00, 0, 16'h0000, 8'h05));
        tbl.push_back(mk(8'h00, 0, 1, 0, 2'd2, 8'h00, 0, 16'h0000, 8'h04));
        tbl.push_back(mk(8'h00, 0, 0, 0, 2'd1, 8'h00, 0, 16'h0000, 8'h40));
        tbl.push_back(mk(8'h00, 0, 0, 1, 2'd1, 8'h40, 0, 16'h0000, 8'h00));
        tbl.push_back(mk(8'h00, 0, 1, 0, 2'd2, 8'h00, 0, 16'h0000, 8'h00));

        reset = 1'b0; int_e = '0; irq_ack = 1'b0; irq_ret = 1'b0;
        cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
        tick();
        tick();
        check_req("reset", 1'b0, 16'h0000);
        check("reset.vec", 32'(irq_vec), 32'h0);
        rd_check("reset.imr", 2'd0, 8'h00);
        rd_check("reset.ipr", 2'd1, 8'h00);
        rd_check("reset.isr", 2'd2, 8'h00);
        rd_check("reset.ctrl", 2'd3, 8'h00);
        reset = 1'b1;

        foreach (tbl[i]) begin
            int_e    = tbl[i].ex;
            irq_ack  = tbl[i].ack;
            irq_ret  = tbl[i].ret;
            cfg_we   = tbl[i].we;
            cfg_addr = tbl[i].addr;
            cfg_wdata = tbl[i].wd;
            tick();
            check_req($sformatf("tbl[%0d]", i), tbl[i].exp_req, tbl[i].exp_vec);
            check($sformatf("tbl[%0d].rd", i), 32'(cfg_rdata), 32'(tbl[i].exp_rd));
        end
        int_e = '0; irq_ack = 1'b0; irq_ret = 1'b0; cfg_we = 1'b0; cfg_wdata = '0;

        // Withdrawal by W1C, then by mask, then by gie.
        int_e = 8'h10;
        repeat (3) tick();
        rd_check("wd.ipr_set", 2'd1, 8'h10);
        tick();
        check_req("wd.req", 1'b1, 16'h0020);
        wr(2'd1, 8'h10);
        tick();
        check_req("wd.w1c", 1'b0, 16'h0000);
        rd_check("wd.w1c_isr", 2'd2, 8'h00);
        rd_check("wd.w1c_ipr", 2'd1, 8'h00);
        int_e = 8'h00;
        repeat (3) tick();
        int_e = 8'h10;
        repeat (4) tick();
        check_req("wd.req2", 1'b1, 16'h0020);
        wr(2'd0, 8'hEF);
        tick();
        check_req("wd.imr", 1'b0, 16'h0000);
        rd_check("wd.imr_isr", 2'd2, 8'h00);
        rd_check("wd.imr_ipr", 2'd1, 8'h10);
        wr(2'd0, 8'hFF);
        tick();
        check_req("wd.req3", 1'b1, 16'h0020);
        wr(2'd3, 8'h00);
        tick();
        check_req("wd.gie", 1'b0, 16'h0000);
        rd_check("wd.gie_isr", 2'd2, 8'h00);
        wr(2'd3, 8'h01);
        tick();
        check_req("wd.req4", 1'b1, 16'h0020);

        // New edge coinciding with the ack clear of the same bit: pending survives.
        int_e = 8'h00;
        repeat (3) tick();
        int_e = 8'h10;
        tick();
        tick();
        pulse_ack();
        check_req("sim.edge_ack", 1'b0, 16'h0000);
        rd_check("sim.edge_ack_ipr", 2'd1, 8'h10);
        rd_check("sim.edge_ack_isr", 2'd2, 8'h10);
        tick();
        check_req("sim.equal_prio", 1'b0, 16'h0000);

        // Return and acknowledge in the same cycle.
        int_e = 8'h12;
        repeat (4) tick();
        check_req("sim.nest", 1'b1, 16'h0014);
        irq_ack = 1'b1;
        irq_ret = 1'b1;
        tick();
        irq_ack = 1'b0;
        irq_ret = 1'b0;
        check_req("sim.ret_ack", 1'b0, 16'h0000);
        rd_check("sim.ret_ack_isr", 2'd2, 8'h02);
        rd_check("sim.ret_ack_ipr", 2'd1, 8'h10);
        pulse_ret();
        rd_check("sim.ret_isr", 2'd2, 8'h00);
        tick();
        check_req("sim.req4", 1'b1, 16'h0020);

        // New edge coinciding with a W1C of the same bit: pending survives.
        int_e = 8'h02;
        repeat (3) tick();
        int_e = 8'h12;
        tick();
        tick();
        wr(2'd1, 8'h10);
        rd_check("sim.edge_w1c_ipr", 2'd1, 8'h10);
        pulse_ack();
        pulse_ret();
        int_e = 8'h00;
        repeat (3) tick();
        check_req("sim.idle", 1'b0, 16'h0000);
        rd_check("sim.idle_isr", 2'd2, 8'h00);

        // Masked source held at a level: pends once, requests when unmasked.
        wr(2'd0, 8'h00);
        int_e = 8'h04;
        repeat (3) tick();
        rd_check("lvl.ipr", 2'd1, 8'h04);
        tick();
        check_req("lvl.masked", 1'b0, 16'h0000);
        wr(2'd0, 8'h04);
        tick();
        check_req("lvl.unmasked", 1'b1, 16'h0018);
        pulse_ack();
        check_req("lvl.ack", 1'b0, 16'h0000);
        rd_check("lvl.isr", 2'd2, 8'h04);
        repeat (4) tick();
        rd_check("lvl.no_reset", 2'd1, 8'h00);
        check_req("lvl.no_req", 1'b0, 16'h0000);

        // Reset while requesting with a source in service; a pulse between edges is ignored.
        wr(2'd0, 8'hFF);
        int_e = 8'h05;
        repeat (4) tick();
        check_req("rst.pre", 1'b1, 16'h0010);
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        tick();
        check_req("rst.glitch", 1'b1, 16'h0010);
        rd_check("rst.glitch_isr", 2'd2, 8'h04);
        reset = 1'b0;
        tick();
        check_req("rst.req", 1'b0, 16'h0000);
        check("rst.vec", 32'(irq_vec), 32'h0);
        rd_check("rst.imr", 2'd0, 8'h00);
        rd_check("rst.ipr", 2'd1, 8'h00);
        rd_check("rst.isr", 2'd2, 8'h00);
        rd_check("rst.ctrl", 2'd3, 8'h00);
        reset = 1'b1;
        int_e = 8'h00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
